// File: rtl/display_driver_if.sv
// Bundle of the value to display and the scanned LED outputs.
// The driver takes the slave view. A bench or upstream block takes the master view.
interface display_driver_if;
    logic [23:0] number;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [23:0] bcd;
    logic        over_range;

    modport master (output number, input an, seg, dp, bcd, over_range);
    modport slave  (input number, output an, seg, dp, bcd, over_range);
endinterface

// File: rtl/display_driver.sv
// Six-digit multiplexed 7-segment driver (HH.MM.SS).
// A free-running double-dabble converter feeds a registered anode/segment scanner.
module display_driver #(
    parameter int REFRESH_COUNT = 100_000,
    parameter bit DP_EN         = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    display_driver_if.slave bus
);
    localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [23:0] latched_reg, latched_next;
    logic [23:0] sreg_reg, sreg_next;
    logic [23:0] acc_reg, acc_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [23:0] bcd_reg, bcd_next;
    logic        over_reg, over_next;
    logic [23:0] adj;

    logic [CW-1:0] refresh_reg, refresh_next;
    logic [2:0]    scan_reg, scan_next;
    logic [7:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic [3:0]    digit [8];

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                    acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
        end
        // Scan positions 6 and 7 map to a blank nibble.
        for (gi = 0; gi < 8; gi++) begin : g_digit
            if (gi < 6) begin : g_live
                assign digit[gi] = bcd_reg[gi*4 +: 4];
            end else begin : g_blank
                assign digit[gi] = 4'hF;
            end
        end
    endgenerate

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            latched_reg <= '0;
            sreg_reg    <= '0;
            acc_reg     <= '0;
            bit_cnt_reg <= '0;
            bcd_reg     <= '0;
            over_reg    <= 1'b0;
            refresh_reg <= '0;
            scan_reg    <= '0;
            an_reg      <= 8'hFF;
            seg_reg     <= 7'h7F;
            dp_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            latched_reg <= latched_next;
            sreg_reg    <= sreg_next;
            acc_reg     <= acc_next;
            bit_cnt_reg <= bit_cnt_next;
            bcd_reg     <= bcd_next;
            over_reg    <= over_next;
            refresh_reg <= refresh_next;
            scan_reg    <= scan_next;
            an_reg      <= an_next;
            seg_reg     <= seg_next;
            dp_reg      <= dp_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        latched_next = latched_reg;
        sreg_next    = sreg_reg;
        acc_next     = acc_reg;
        bit_cnt_next = bit_cnt_reg;
        bcd_next     = bcd_reg;
        over_next    = over_reg;
        case (state_reg)
            IDLE: begin
                latched_next = bus.number;
                sreg_next    = bus.number;
                acc_next     = '0;
                bit_cnt_next = '0;
                state_next   = SHIFT;
            end
            SHIFT: begin
                // Carries out of digit 5 are dropped; over_range flags that case.
                acc_next     = {adj[22:0], sreg_reg[23]};
                sreg_next    = {sreg_reg[22:0], 1'b0};
                bit_cnt_next = bit_cnt_reg + 5'd1;
                if (bit_cnt_reg == 5'd23) state_next = DONE;
            end
            DONE: begin
                bcd_next   = acc_reg;
                over_next  = (latched_reg > 24'd999_999);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        refresh_next = refresh_reg + CW'(1);
        scan_next    = scan_reg;
        if (refresh_reg == REFRESH_LAST) begin
            refresh_next = '0;
            scan_next    = scan_reg + 3'd1;
        end
    end

    always_comb begin
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (scan_reg < 3'd6) begin
            an_next  = ~(8'b1 << scan_reg);
            seg_next = over_reg ? 7'b0111111 : seg_code(digit[scan_reg]);
            dp_next  = !(DP_EN && (scan_reg == 3'd2 || scan_reg == 3'd4));
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.dp         = dp_reg;
    assign bus.bcd        = bcd_reg;
    assign bus.over_range = over_reg;
endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: two instances (separators on / off) checked against
// an arithmetic model of the conversion cadence and the scan position.
module tb_display_driver;
    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] number = '0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    display_driver_if bus_a ();
    display_driver_if bus_b ();
    assign bus_a.number = number;
    assign bus_b.number = number;

    display_driver #(.REFRESH_COUNT(RC), .DP_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    display_driver #(.REFRESH_COUNT(RC), .DP_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Reference model: k counts edges since reset release. A conversion latches
    // on edges 1, 27, 53, ... and publishes on edges 26, 52, ...
    logic [6:0] seg_tab [10];
    int         k = 0;
    int         latched = 0;
    int         shown = 0;
    logic       exp_over = 1'b0;
    logic [7:0] exp_an = 8'hFF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;

    function automatic int pow10(input int p);
        int r = 1;
        for (int i = 0; i < p; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            k        <= 0;
            shown    <= 0;
            exp_over <= 1'b0;
            exp_an   <= 8'hFF;
            exp_seg  <= 7'h7F;
            exp_dp   <= 1'b1;
        end else begin
            k <= k + 1;
            if (k % 26 == 0) latched <= int'(number);
            if (k % 26 == 25) begin
                shown    <= latched % 1000000;
                exp_over <= (latched > 999999);
            end
            if ((k / RC) % 8 < 6) begin
                exp_an  <= ~(8'b1 << ((k / RC) % 8));
                exp_seg <= exp_over ? 7'b0111111 : seg_tab[(shown / pow10((k / RC) % 8)) % 10];
                exp_dp  <= !(((k / RC) % 8 == 2) || ((k / RC) % 8 == 4));
            end else begin
                exp_an  <= 8'hFF;
                exp_seg <= 7'h7F;
                exp_dp  <= 1'b1;
            end
        end
    end

    logic [40:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {bus_a.an, bus_a.seg, bus_a.dp, bus_a.bcd, bus_a.over_range};
    assign obs_b = {bus_b.an, bus_b.seg, bus_b.dp, bus_b.bcd, bus_b.over_range};
    assign exp_a = {exp_an, exp_seg, exp_dp, to_bcd(shown), exp_over};
    assign exp_b = {exp_an, exp_seg, 1'b1, to_bcd(shown), exp_over};

    task automatic test_reset;
        number = 24'd123456;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_a !== {8'hFF, 7'h7F, 1'b1, 24'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_a: got %h, want %h", obs_a, {8'hFF, 7'h7F, 1'b1, 24'h0, 1'b0});
        end
        vectors++;
        if (obs_b !== {8'hFF, 7'h7F, 1'b1, 24'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_b: got %h, want %h", obs_b, {8'hFF, 7'h7F, 1'b1, 24'h0, 1'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_a.an !== 8'hFE) begin
            miscompares++;
            $display("FAIL first_anode: an=%h, want fe", bus_a.an);
        end
    endtask

    task automatic test_decode;
        repeat (24) @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h0) begin
            miscompares++;
            $display("FAIL early_bcd: bcd=%h, want 000000", bus_a.bcd);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h123456 || bus_a.over_range !== 1'b0) begin
            miscompares++;
            $display("FAIL decode_123456: bcd=%h ovr=%b, want 123456 0", bus_a.bcd, bus_a.over_range);
        end
        for (int i = 0; i < 40 && bus_a.an !== 8'hFE; i++) @(negedge clk);
        vectors++;
        if (bus_a.an !== 8'hFE || bus_a.seg !== 7'b0000010) begin
            miscompares++;
            $display("FAIL digit0_seg: an=%h seg=%b, want fe 0000010", bus_a.an, bus_a.seg);
        end
    endtask

    task automatic test_scan;
        int dp_low = 0;
        int blank = 0;
        number = 24'd235959;
        repeat (60) @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL scan_a k=%0d: got %h, want %h", k, obs_a, exp_a);
            end
            if (bus_a.dp === 1'b0) dp_low++;
            if (bus_a.an === 8'hFF) blank++;
            if (bus_a.dp === 1'b0 && bus_a.an !== 8'hFB && bus_a.an !== 8'hEF) begin
                miscompares++;
                $display("FAIL dp_position: dp=0 at an=%h, want fb or ef", bus_a.an);
            end
        end
        vectors++;
        if (dp_low != 32 || blank != 32 || bus_a.bcd !== 24'h235959) begin
            miscompares++;
            $display("FAIL scan_totals: dp_low=%0d blank=%0d bcd=%h, want 32 32 235959",
                     dp_low, blank, bus_a.bcd);
        end
    endtask

    task automatic test_over_range;
        int i;
        number = 24'd1_000_000;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            vectors++;
            if (obs_a !== exp_a) begin
                miscompares++;
                $display("FAIL over_a k=%0d: got %h, want %h", k, obs_a, exp_a);
            end
        end
        for (i = 0; i < 40 && bus_a.an !== 8'hFE; i++) @(negedge clk);
        vectors++;
        if (bus_a.over_range !== 1'b1 || bus_a.seg !== 7'b0111111) begin
            miscompares++;
            $display("FAIL over_dash: ovr=%b seg=%b, want 1 0111111", bus_a.over_range, bus_a.seg);
        end
        number = 24'd999_999;
        for (i = 0; i < 52; i++) begin
            @(negedge clk);
            if (bus_a.bcd === 24'h999999 && bus_a.over_range === 1'b0) break;
        end
        vectors++;
        if (bus_a.bcd !== 24'h999999 || bus_a.over_range !== 1'b0) begin
            miscompares++;
            $display("FAIL recover_999999: bcd=%h ovr=%b, want 999999 0 within 52", bus_a.bcd, bus_a.over_range);
        end
    endtask

    task automatic test_midshift;
        for (int i = 0; i < 30 && k % 26 != 0; i++) @(negedge clk);
        number = 24'd59;
        repeat (11) @(negedge clk);
        number = 24'd100;
        repeat (15) @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h000059) begin
            miscompares++;
            $display("FAIL midshift_hold: bcd=%h, want 000059", bus_a.bcd);
        end
        repeat (26) @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h000100) begin
            miscompares++;
            $display("FAIL midshift_next: bcd=%h, want 000100", bus_a.bcd);
        end
    endtask

    task automatic test_reset_mid;
        number = 24'd120000;
        repeat (60) @(negedge clk);
        for (int i = 0; i < 30 && k % 26 != 10; i++) @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h120000) begin
            miscompares++;
            $display("FAIL pre_reset_bcd: bcd=%h, want 120000", bus_a.bcd);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h0 || bus_a.an !== 8'hFF || bus_a.seg !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_abort: bcd=%h an=%h seg=%h, want 000000 ff 7f", bus_a.bcd, bus_a.an, bus_a.seg);
        end
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_hold_zero: bcd=%h, want 000000", bus_a.bcd);
        end
        @(negedge clk);
        vectors++;
        if (bus_a.bcd !== 24'h120000) begin
            miscompares++;
            $display("FAIL reset_reconvert: bcd=%h, want 120000", bus_a.bcd);
        end
    endtask

    task automatic test_dp_disable;
        number = 24'd0;
        repeat (60) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_b.dp !== 1'b1 || (bus_b.an !== 8'hFF && bus_b.seg !== 7'b1000000) || obs_b !== exp_b) begin
                miscompares++;
                $display("FAIL dp_disable k=%0d: got %h, want %h", k, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) number = 24'($urandom_range(24'hFFFFFF, 1000000));
            else number = 24'($urandom_range(999999, 0));
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int c = 0; c < int'($urandom_range(70, 10)); c++) begin
                @(negedge clk);
                vectors++;
                if (obs_a !== exp_a) begin
                    miscompares++;
                    $display("FAIL random_a num=%0d k=%0d: got %h, want %h", number, k, obs_a, exp_a);
                end
                vectors++;
                if (obs_b !== exp_b) begin
                    miscompares++;
                    $display("FAIL random_b num=%0d k=%0d: got %h, want %h", number, k, obs_b, exp_b);
                end
            end
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        @(negedge clk);
        test_reset();
        test_decode();
        test_scan();
        test_over_range();
        test_midshift();
        test_reset_mid();
        test_dp_disable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
